// File: rtl/umem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
//   state_e : sequencer states (IDLE, REQ, RESP)
//   owner_e : which port owns the outstanding transaction
package umem_arb_pkg;

  localparam int unsigned AW_DEF          = 32;
  localparam int unsigned DW_DEF          = 32;
  localparam int unsigned MAX_D_BURST_DEF = 4;
  localparam int unsigned TIMEOUT_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

endpackage

// File: rtl/umem_wdog.sv
// Transaction watchdog: counts cycles while enabled and flags the edge on
// which the count reaches TIMEOUT. TIMEOUT = 0 disables it.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : zero the count (transaction start)
//   en        : count this cycle (transaction in flight)
//   expire_c  : combinational, count reaches TIMEOUT on this edge
module umem_wdog
  import umem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] cnt_q;

  // Cycle counter; holds once expired until the next clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_c = (TIMEOUT != 0) && en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/umem_arbiter.sv
// Arbiter/sequencer sharing one single-ported variable-latency memory
// between the fetch port (if_*) and the load/store port (d_*). One
// transaction in flight; data has priority, but fetch is forced after
// MAX_D_BURST back-to-back data grants while fetch waits. A watchdog
// aborts a transaction that stalls for TIMEOUT cycles.
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata     fetch port
//   d_req/d_we/d_addr/d_wdata/d_be -> d_gnt, d_rvalid, d_rdata
//   m_req/m_we/m_addr/m_wdata/m_be <- m_gnt, m_rvalid, m_rdata
//   err : one-cycle pulse on watchdog abort
module umem_arbiter
  import umem_arb_pkg::*;
#(
  parameter int unsigned AW          = AW_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned MAX_D_BURST = MAX_D_BURST_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata,
  output logic            err
);

  localparam int unsigned BW  = DW / 8;
  localparam int unsigned BCW = (MAX_D_BURST > 0) ? $clog2(MAX_D_BURST + 1) : 1;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  logic [BCW-1:0]  burst_q, burst_d;

  logic            if_gnt_d, if_rvalid_d, d_gnt_d, d_rvalid_d, err_d;
  logic [DW-1:0]   if_rdata_d, d_rdata_d;
  logic            m_req_d, m_we_d;
  logic [AW-1:0]   m_addr_d;
  logic [DW-1:0]   m_wdata_d;
  logic [BW-1:0]   m_be_d;

  logic            pick_if_c, rsp_fire_c, wd_clr_c, wd_en_c, wd_exp_c;
  logic [DW-1:0]   rsp_data_c;

  assign wd_en_c = (state_q != IDLE);

  umem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr      (wd_clr_c),
    .en       (wd_en_c),
    .expire_c (wd_exp_c)
  );

  // Next state, arbitration and registered-output next values.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_d     = burst_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    m_req_d     = m_req;
    m_we_d      = m_we;
    m_addr_d    = m_addr;
    m_wdata_d   = m_wdata;
    m_be_d      = m_be;
    pick_if_c   = 1'b0;
    rsp_fire_c  = 1'b0;
    rsp_data_c  = '0;
    wd_clr_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          pick_if_c = if_req && (!d_req || (burst_q == BCW'(MAX_D_BURST)));
          state_d   = REQ;
          m_req_d   = 1'b1;
          wd_clr_c  = 1'b1;
          if (pick_if_c) begin
            owner_d   = OWN_IF;
            if_gnt_d  = 1'b1;
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_be_d    = '1;
            burst_d   = '0;
          end else begin
            owner_d   = OWN_D;
            d_gnt_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
            // Only back-to-back data grants that starve a waiting fetch count.
            if (!if_req) begin
              burst_d = '0;
            end else if (burst_q != BCW'(MAX_D_BURST)) begin
              burst_d = burst_q + BCW'(1);
            end
          end
        end
      end
      REQ: begin
        // Timeout wins over a same-edge grant; a response here is ignored.
        if (wd_exp_c) begin
          m_req_d    = 1'b0;
          err_d      = 1'b1;
          rsp_fire_c = 1'b1;
          state_d    = IDLE;
        end else if (m_gnt) begin
          m_req_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: begin
        // A real response on the expiry edge still completes normally.
        if (m_rvalid) begin
          rsp_fire_c = 1'b1;
          rsp_data_c = m_we ? '0 : m_rdata;
          state_d    = IDLE;
        end else if (wd_exp_c) begin
          err_d      = 1'b1;
          rsp_fire_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase

    // Route the response to the owner; the other port's rdata holds.
    if (rsp_fire_c) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rsp_data_c;
      end else begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = rsp_data_c;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IF;
      burst_q   <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_be      <= '0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      if_gnt    <= if_gnt_d;
      if_rvalid <= if_rvalid_d;
      if_rdata  <= if_rdata_d;
      d_gnt     <= d_gnt_d;
      d_rvalid  <= d_rvalid_d;
      d_rdata   <= d_rdata_d;
      m_req     <= m_req_d;
      m_we      <= m_we_d;
      m_addr    <= m_addr_d;
      m_wdata   <= m_wdata_d;
      m_be      <= m_be_d;
      err       <= err_d;
    end
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// Self-checking bench for umem_arbiter: single-transaction vector table,
// directed contention/fairness/watchdog/reset sequences, then randomized
// traffic checked against a transaction-level reference model.
module tb_umem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int          MAXB = 4;
  localparam int          TMO  = 16;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req, d_we;
  logic [31:0]   d_addr, d_wdata;
  logic [3:0]    d_be;
  logic          d_gnt, d_rvalid;
  logic [31:0]   d_rdata;
  logic          m_req, m_we;
  logic [31:0]   m_addr, m_wdata;
  logic [3:0]    m_be;
  logic          m_gnt, m_rvalid;
  logic [31:0]   m_rdata;
  logic          err;

  umem_arbiter #(.AW(AW), .DW(DW), .MAX_D_BURST(MAXB), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    if_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " m_req"},     32'(m_req),     32'd0);
    chk({tag, " m_we"},      32'(m_we),      32'd0);
    chk({tag, " m_addr"},    m_addr,         32'd0);
    chk({tag, " m_wdata"},   m_wdata,        32'd0);
    chk({tag, " m_be"},      32'(m_be),      32'd0);
    chk({tag, " if_gnt"},    32'(if_gnt),    32'd0);
    chk({tag, " d_gnt"},     32'(d_gnt),     32'd0);
    chk({tag, " if_rvalid"}, 32'(if_rvalid), 32'd0);
    chk({tag, " d_rvalid"},  32'(d_rvalid),  32'd0);
    chk({tag, " if_rdata"},  if_rdata,       32'd0);
    chk({tag, " d_rdata"},   d_rdata,        32'd0);
    chk({tag, " err"},       32'(err),       32'd0);
  endtask

  // Memory that grants at once and responds one cycle later with ~addr.
  bit          auto_acc = 1'b0;
  logic [31:0] auto_addr = '0;
  task automatic auto_cycle();
    tick();
    m_rvalid = auto_acc;
    m_rdata  = ~auto_addr;
    auto_acc = 1'b0;
    m_gnt    = m_req;
    if (m_req) begin
      auto_acc  = 1'b1;
      auto_addr = m_addr;
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gd;        // cycles m_req waits before m_gnt
    int          rd;        // RESP cycles before m_rvalid
    logic [31:0] mem_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    int          exp_lat;   // request cycle to rvalid cycle
    int          exp_mreq;  // cycles m_req is high
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int k, j, nmreq, lat;
    bit in_resp;
    logic [31:0] got;
    k = 0; j = 0; nmreq = 0; lat = -1; in_resp = 1'b0; got = '0;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
      tick();
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = v.mem_rdata;
      if (cyc == 1)
        chk($sformatf("vec%0d gnt{if,d}", idx), 32'({if_gnt, d_gnt}), v.is_d ? 32'd1 : 32'd2);
      if (if_gnt || d_gnt) begin
        if_req = 1'b0; d_req = 1'b0;
      end
      if (m_req) begin
        nmreq++;
        chk($sformatf("vec%0d m_addr", idx), m_addr, v.addr);
        chk($sformatf("vec%0d m_we", idx), 32'(m_we), 32'(v.is_d & v.we));
        chk($sformatf("vec%0d m_be", idx), 32'(m_be), 32'(v.exp_be));
        if (v.is_d) chk($sformatf("vec%0d m_wdata", idx), m_wdata, v.wdata);
        if (k == v.gd) begin
          m_gnt = 1'b1; in_resp = 1'b1;
        end
        k++;
      end else if (in_resp) begin
        if (j == v.rd) m_rvalid = 1'b1;
        j++;
      end
      if (if_rvalid || d_rvalid) begin
        lat = cyc;
        got = v.is_d ? d_rdata : if_rdata;
        chk($sformatf("vec%0d rvalid{if,d}", idx), 32'({if_rvalid, d_rvalid}), v.is_d ? 32'd1 : 32'd2);
        chk($sformatf("vec%0d err", idx), 32'(err), 32'd0);
      end
    end
    chk($sformatf("vec%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("vec%0d rdata", idx), got, v.exp_rdata);
    chk($sformatf("vec%0d m_req cycles", idx), 32'(nmreq), 32'(v.exp_mreq));
    tick();
  endtask

  // Reference model state for the random phase.
  bit          md_busy, md_acc, md_own_d, md_we;
  int          md_age, md_burst;
  logic [31:0] md_addr, md_wdata;
  logic [3:0]  md_be;
  logic [31:0] e_if_rdata, e_d_rdata;

  initial begin
    #2000000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    int          gc_d, gc_i, rc_d, rc_i;
    logic [31:0] ga_d, ga_i, rd_d, rd_i;
    int          order[10];
    int          ngr, err_cyc, err_cnt, late_rv, rv_cyc;
    logic [31:0] rv_data;
    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_mreq, fire, pick_if;
    logic [31:0] rsp;

    vecs[0] = '{1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 0, 0, 32'h00500093, 4'hF, 32'h00500093, 3, 1};
    vecs[1] = '{1'b1, 1'b0, 32'h2000, 32'h11111111, 4'hF, 0, 0, 32'h12345678, 4'hF, 32'h12345678, 3, 1};
    vecs[2] = '{1'b1, 1'b1, 32'h40,   32'hDEADBEEF, 4'h3, 3, 0, 32'hFFFFFFFF, 4'h3, 32'h0,        6, 4};
    vecs[3] = '{1'b1, 1'b0, 32'h44,   32'h0,        4'hF, 1, 2, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 6, 2};
    vecs[4] = '{1'b0, 1'b0, 32'h104,  32'h0,        4'h0, 2, 3, 32'h0BADC0DE, 4'hF, 32'h0BADC0DE, 8, 3};
    vecs[5] = '{1'b1, 1'b1, 32'h48,   32'h01020304, 4'hC, 0, 4, 32'h77777777, 4'hC, 32'h0,        7, 1};

    rst = 1'b1; quiet_inputs();
    if_addr = '0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0; m_rdata = '0;
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single transactions with assorted wait states.
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Contention: load and fetch rise together.
    gc_d = -1; gc_i = -1; rc_d = -1; rc_i = -1;
    ga_d = '0; ga_i = '0; rd_d = '0; rd_i = '0;
    if_req = 1'b1; if_addr = 32'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = '0; d_be = 4'hF;
    for (int c = 1; c <= 10; c++) begin
      auto_cycle();
      if (d_gnt)     begin gc_d = c; ga_d = m_addr; d_req = 1'b0; end
      if (if_gnt)    begin gc_i = c; ga_i = m_addr; if_req = 1'b0; end
      if (d_rvalid)  begin rc_d = c; rd_d = d_rdata; end
      if (if_rvalid) begin rc_i = c; rd_i = if_rdata; end
    end
    chk("cont d_gnt cycle",     32'(gc_d), 32'd1);
    chk("cont d m_addr",        ga_d,      32'h2000);
    chk("cont d_rvalid cycle",  32'(rc_d), 32'd3);
    chk("cont d_rdata",         rd_d,      ~32'h2000);
    chk("cont if_gnt cycle",    32'(gc_i), 32'd4);
    chk("cont if m_addr",       ga_i,      32'h300);
    chk("cont if_rvalid cycle", 32'(rc_i), 32'd6);
    chk("cont if_rdata",        rd_i,      ~32'h300);

    // Fairness: both ports request continuously.
    ngr = 0;
    if_req = 1'b1; if_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      auto_cycle();
      if (d_gnt)  begin order[ngr] = 1; ngr++; d_addr = d_addr + 32'd4; end
      if (if_gnt) begin order[ngr] = 0; ngr++; if_addr = if_addr + 32'd4; end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("fair grant count", 32'(ngr), 32'd10);
    for (int g = 0; g < 10; g++)
      chk($sformatf("fair grant %0d is_data", g), 32'(order[g]), (g % 5 == 4) ? 32'd0 : 32'd1);
    for (int c = 0; c < 4; c++) auto_cycle();
    m_gnt = 1'b0; m_rvalid = 1'b0;

    // Reset while waiting in RESP; a later m_rvalid must be ignored.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90;
    tick();
    chk("rst d_gnt", 32'(d_gnt), 32'd1);
    d_req = 1'b0; m_gnt = 1'b1;
    tick();
    m_gnt = 1'b0; rst = 1'b1;
    tick();
    chk_all_zero("rst mid");
    rst = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5A5A5;
    late_rv = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      m_rvalid = 1'b0;
      if (if_rvalid || d_rvalid || m_req) late_rv++;
    end
    chk("rst ignored rvalid", 32'(late_rv), 32'd0);

    // Watchdog: memory grants but never responds.
    run_vec(1, vecs[1]);
    err_cyc = -1; err_cnt = 0; rv_cyc = -1; rv_data = 32'hFFFFFFFF; late_rv = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (d_gnt) d_req = 1'b0;
      m_gnt    = m_req;
      m_rvalid = (c == 18);
      m_rdata  = 32'h5555AAAA;
      if (err) begin err_cnt++; err_cyc = c; end
      if (d_rvalid && c < 18) begin rv_cyc = c; rv_data = d_rdata; end
      if ((if_rvalid || d_rvalid) && c > 18) late_rv++;
    end
    m_gnt = 1'b0; m_rvalid = 1'b0;
    chk("wdog err cycle",      32'(err_cyc), 32'd17);
    chk("wdog err pulses",     32'(err_cnt), 32'd1);
    chk("wdog d_rvalid cycle", 32'(rv_cyc),  32'd17);
    chk("wdog d_rdata",        rv_data,      32'd0);
    chk("wdog late rvalid",    32'(late_rv), 32'd0);
    run_vec(0, vecs[0]);

    // Random traffic against the transaction-level model.
    rst = 1'b1; quiet_inputs();
    tick(); tick();
    rst = 1'b0;
    md_busy = 1'b0; md_acc = 1'b0; md_age = 0; md_burst = 0;
    md_own_d = 1'b0; md_we = 1'b0; md_addr = '0; md_wdata = '0; md_be = '0;
    e_if_rdata = '0; e_d_rdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit slow;
      tick();
      e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0; e_err = 1'b0;
      fire = 1'b0; rsp = '0; pick_if = 1'b0;
      if (md_busy) begin
        md_age++;
        if (md_acc && m_rvalid) begin
          fire = 1'b1; rsp = md_we ? 32'd0 : m_rdata;
        end else if (md_age == TMO) begin
          fire = 1'b1; rsp = 32'd0; e_err = 1'b1;
        end else if (!md_acc && m_gnt) begin
          md_acc = 1'b1;
        end
        if (fire) begin
          md_busy = 1'b0;
          if (md_own_d) begin e_d_rv = 1'b1; e_d_rdata = rsp; end
          else          begin e_if_rv = 1'b1; e_if_rdata = rsp; end
        end
      end else if (if_req || d_req) begin
        pick_if = if_req && (!d_req || md_burst == MAXB);
        md_busy = 1'b1; md_acc = 1'b0; md_age = 0;
        if (pick_if) begin
          md_own_d = 1'b0; md_we = 1'b0; md_addr = if_addr; md_be = 4'hF;
          md_burst = 0; e_if_gnt = 1'b1;
        end else begin
          md_own_d = 1'b1; md_we = d_we; md_addr = d_addr; md_wdata = d_wdata; md_be = d_be;
          md_burst = !if_req ? 0 : (md_burst < MAXB ? md_burst + 1 : md_burst);
          e_d_gnt = 1'b1;
        end
      end
      e_mreq = md_busy && !md_acc;
      chk("rnd if_gnt",    32'(if_gnt),    32'(e_if_gnt));
      chk("rnd d_gnt",     32'(d_gnt),     32'(e_d_gnt));
      chk("rnd if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("rnd d_rvalid",  32'(d_rvalid),  32'(e_d_rv));
      chk("rnd if_rdata",  if_rdata,       e_if_rdata);
      chk("rnd d_rdata",   d_rdata,        e_d_rdata);
      chk("rnd err",       32'(err),       32'(e_err));
      chk("rnd m_req",     32'(m_req),     32'(e_mreq));
      if (e_mreq) begin
        chk("rnd m_addr", m_addr,     md_addr);
        chk("rnd m_we",   32'(m_we),  32'(md_we));
        chk("rnd m_be",   32'(m_be),  32'(md_be));
        if (md_own_d) chk("rnd m_wdata", m_wdata, md_wdata);
      end

      slow = ((cyc / 256) % 4) == 3;
      if (if_gnt || !if_req) begin
        if_req  = ($urandom % 2) == 1;
        if_addr = $urandom & 32'hFFFFFFFC;
      end
      if (d_gnt || !d_req) begin
        d_req   = ($urandom % 3) != 0;
        d_we    = ($urandom % 2) == 1;
        d_addr  = $urandom & 32'hFFFFFFFC;
        d_wdata = $urandom;
        d_be    = 4'($urandom);
      end
      m_gnt    = slow ? (($urandom % 12) == 0) : (($urandom % 3) != 0);
      m_rvalid = slow ? (($urandom % 12) == 0) : (($urandom % 3) != 0);
      m_rdata  = $urandom;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
